mem_test_ctrl: RTL and testbench

- Control/status block for the memory checker, on the system clock domain.
- Avalon-MM slave exposes a control register, three test-configuration registers (CSR_1..CSR_3) and ten read-only result registers.
- Sequences one test run: pulses start to the checker, waits for completion or watchdog timeout, and latches the 320-bit result bundle into a shadow for readback.

---
 rtl/mem_checker_pkg.sv | 59 +++++
 rtl/mem_test_watchdog.sv | 36 +++
 rtl/mem_test_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_mem_test_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_checker_pkg.sv
// Shared definitions for the memory checker control block: register map,
// CTRL bit positions, bus payload structs and the run sequencer states.
package mem_checker_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_RES = 10;

  // Word addresses on the CSR slave port
  localparam int unsigned CTRL_ADDR     = 0;
  localparam int unsigned CSR_1_ADDR    = 1;
  localparam int unsigned CSR_2_ADDR    = 2;
  localparam int unsigned CSR_3_ADDR    = 3;
  localparam int unsigned RESULT_ADDR   = 4;
  localparam int unsigned ERR_ADDR_ADDR = 5;
  localparam int unsigned ERR_DATA_ADDR = 6;
  localparam int unsigned WR_TICKS_ADDR = 7;
  localparam int unsigned WR_UNITS_ADDR = 8;
  localparam int unsigned RD_TICKS_ADDR = 9;
  localparam int unsigned RD_WORDS_ADDR = 10;
  localparam int unsigned MIN_MAX_ADDR  = 11;
  localparam int unsigned SUM_ADDR      = 12;
  localparam int unsigned RD_REQ_ADDR   = 13;

  // CTRL register bit positions
  localparam int unsigned CTRL_START_BIT   = 0;
  localparam int unsigned CTRL_BUSY_BIT    = 1;
  localparam int unsigned CTRL_DONE_BIT    = 2;
  localparam int unsigned CTRL_TIMEOUT_BIT = 3;
  localparam int unsigned CTRL_WR_ERR_BIT  = 4;
  localparam int unsigned CTRL_IRQ_EN_BIT  = 8;

  // Test configuration handed to the checker, CSR_3 in the MSBs
  typedef struct packed {
    logic [DATA_W-1:0] csr_3;
    logic [DATA_W-1:0] csr_2;
    logic [DATA_W-1:0] csr_1;
  } test_struct_t;

  // Result bundle from the checker, result in the MSBs
  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] err_addr;
    logic [DATA_W-1:0] err_data;
    logic [DATA_W-1:0] wr_ticks;
    logic [DATA_W-1:0] wr_units;
    logic [DATA_W-1:0] rd_ticks;
    logic [DATA_W-1:0] rd_words;
    logic [DATA_W-1:0] min_max;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] rd_req;
  } res_struct_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_test_watchdog.sv
// Saturating run watchdog. expire_c_o flags the cycle whose increment makes
// the count reach limit_i; a limit of 0 never expires.
module mem_test_watchdog (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        enable_i,
  input  logic [31:0] limit_i,
  output logic        expire_c_o
);

  logic [31:0] count_q, count_d;

  // Clear has priority; increment stops at all-ones
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != '1)) begin
      count_d = count_q + 32'd1;
    end
  end

  // Count register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_c_o = enable_i && !clear_i && (limit_i != '0) &&
                      ((33'(count_q) + 33'd1) == 33'(limit_i));

endmodule

// File: rtl/mem_test_ctrl.sv
// Control/status block for the memory checker: Avalon-MM CSR slave, one-shot
// run sequencer with watchdog, and a shadow copy of the checker results.
// Optional interrupt output enabled by defining MEM_TEST_CTRL_IRQ_EN.
module mem_test_ctrl
  import mem_checker_pkg::*;
#(
  parameter logic [31:0]  TIMEOUT_CYCLES = 32'd1_000_000,
  parameter int unsigned  CSR_ADDR_W     = 4
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_n_i,
  input  logic [CSR_ADDR_W-1:0] csr_address_i,
  input  logic                  csr_read_i,
  input  logic                  csr_write_i,
  input  logic [31:0]           csr_writedata_i,
  output logic [31:0]           csr_readdata_o,
  output logic                  csr_readdatavalid_o,
  output logic                  csr_waitrequest_o,
  output logic [95:0]           test_param_o,
  output logic                  start_o,
  output logic                  abort_o,
`ifdef MEM_TEST_CTRL_IRQ_EN
  output logic                  irq_o,
`endif
  input  logic                  done_i,
  input  logic [319:0]          res_i
);

  state_e       state_q, state_d;
  test_struct_t csr_q, csr_d;
  res_struct_t  shadow_q, shadow_d;
  logic         done_q, done_d;
  logic         timeout_q, timeout_d;
  logic         wr_err_q, wr_err_d;
  logic         start_q, start_d;
  logic         abort_q, abort_d;
  logic [31:0]  rdata_q, rdata_d;
  logic         rvalid_q;
  logic [31:0]  addr_c;
  logic [31:0]  rd_data_c;
  logic         busy_c;
  logic         expire_c;
`ifdef MEM_TEST_CTRL_IRQ_EN
  logic         ie_q, ie_d;
  logic         irq_q, irq_d;
`endif

  assign addr_c = 32'(csr_address_i);
  assign busy_c = (state_q != ST_IDLE);

  // Watchdog is zeroed in START and counts every RUN cycle
  mem_test_watchdog u_watchdog (
    .clk_i      (clk_sys_i),
    .rst_n_i    (rst_n_i),
    .clear_i    (state_q == ST_START),
    .enable_i   (state_q == ST_RUN),
    .limit_i    (TIMEOUT_CYCLES),
    .expire_c_o (expire_c)
  );

  // Read mux over current register values (pre-write on a same-cycle write)
  always_comb begin
    rd_data_c = '0;
    case (addr_c)
      CTRL_ADDR: begin
        rd_data_c[CTRL_BUSY_BIT]    = busy_c;
        rd_data_c[CTRL_DONE_BIT]    = done_q;
        rd_data_c[CTRL_TIMEOUT_BIT] = timeout_q;
        rd_data_c[CTRL_WR_ERR_BIT]  = wr_err_q;
`ifdef MEM_TEST_CTRL_IRQ_EN
        rd_data_c[CTRL_IRQ_EN_BIT]  = ie_q;
`endif
      end
      CSR_1_ADDR:    rd_data_c = csr_q.csr_1;
      CSR_2_ADDR:    rd_data_c = csr_q.csr_2;
      CSR_3_ADDR:    rd_data_c = csr_q.csr_3;
      RESULT_ADDR:   rd_data_c = shadow_q.result;
      ERR_ADDR_ADDR: rd_data_c = shadow_q.err_addr;
      ERR_DATA_ADDR: rd_data_c = shadow_q.err_data;
      WR_TICKS_ADDR: rd_data_c = shadow_q.wr_ticks;
      WR_UNITS_ADDR: rd_data_c = shadow_q.wr_units;
      RD_TICKS_ADDR: rd_data_c = shadow_q.rd_ticks;
      RD_WORDS_ADDR: rd_data_c = shadow_q.rd_words;
      MIN_MAX_ADDR:  rd_data_c = shadow_q.min_max;
      SUM_ADDR:      rd_data_c = shadow_q.sum;
      RD_REQ_ADDR:   rd_data_c = shadow_q.rd_req;
      default:       rd_data_c = '0;
    endcase
  end

  // Next state: bus writes first, then sequencer events so sets beat W1C
  always_comb begin
    state_d   = state_q;
    csr_d     = csr_q;
    shadow_d  = shadow_q;
    done_d    = done_q;
    timeout_d = timeout_q;
    wr_err_d  = wr_err_q;
    abort_d   = 1'b0;
    rdata_d   = csr_read_i ? rd_data_c : '0;
`ifdef MEM_TEST_CTRL_IRQ_EN
    ie_d      = ie_q;
`endif

    if (csr_write_i) begin
      case (addr_c)
        CTRL_ADDR: begin
          if (csr_writedata_i[CTRL_DONE_BIT])    done_d    = 1'b0;
          if (csr_writedata_i[CTRL_TIMEOUT_BIT]) timeout_d = 1'b0;
          if (csr_writedata_i[CTRL_WR_ERR_BIT])  wr_err_d  = 1'b0;
`ifdef MEM_TEST_CTRL_IRQ_EN
          ie_d = csr_writedata_i[CTRL_IRQ_EN_BIT];
`endif
          if (csr_writedata_i[CTRL_START_BIT]) begin
            if (busy_c) begin
              wr_err_d = 1'b1;
            end else begin
              state_d   = ST_START;
              done_d    = 1'b0;
              timeout_d = 1'b0;
            end
          end
        end
        CSR_1_ADDR: if (busy_c) wr_err_d = 1'b1; else csr_d.csr_1 = csr_writedata_i;
        CSR_2_ADDR: if (busy_c) wr_err_d = 1'b1; else csr_d.csr_2 = csr_writedata_i;
        CSR_3_ADDR: if (busy_c) wr_err_d = 1'b1; else csr_d.csr_3 = csr_writedata_i;
        default: ;
      endcase
    end

    case (state_q)
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (done_i) begin
          shadow_d = res_struct_t'(res_i);
          done_d   = 1'b1;
          state_d  = ST_IDLE;
        end else if (expire_c) begin
          abort_d   = 1'b1;
          timeout_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: ;
    endcase

    start_d = (state_d == ST_START);
`ifdef MEM_TEST_CTRL_IRQ_EN
    irq_d   = (done_d | timeout_d) & ie_d;
`endif
  end

  // Sequencer state register
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Register file, flags and registered outputs
  always_ff @(posedge clk_sys_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      csr_q     <= '0;
      shadow_q  <= '0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      wr_err_q  <= 1'b0;
      start_q   <= 1'b0;
      abort_q   <= 1'b0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
`ifdef MEM_TEST_CTRL_IRQ_EN
      ie_q      <= 1'b0;
      irq_q     <= 1'b0;
`endif
    end else begin
      csr_q     <= csr_d;
      shadow_q  <= shadow_d;
      done_q    <= done_d;
      timeout_q <= timeout_d;
      wr_err_q  <= wr_err_d;
      start_q   <= start_d;
      abort_q   <= abort_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= csr_read_i;
`ifdef MEM_TEST_CTRL_IRQ_EN
      ie_q      <= ie_d;
      irq_q     <= irq_d;
`endif
    end
  end

  assign csr_readdata_o      = rdata_q;
  assign csr_readdatavalid_o = rvalid_q;
  assign csr_waitrequest_o   = 1'b0;
  assign test_param_o        = csr_q;
  assign start_o             = start_q;
  assign abort_o             = abort_q;
`ifdef MEM_TEST_CTRL_IRQ_EN
  assign irq_o               = irq_q;
`endif

endmodule

// File: tb/tb_mem_test_ctrl.sv
// Self-checking bench for mem_test_ctrl with a 16-cycle watchdog.
`timescale 1ns/1ps
module tb_mem_test_ctrl;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [3:0]   addr = '0;
  logic         rd = 1'b0, wr = 1'b0;
  logic [31:0]  wdata = '0;
  logic [31:0]  rdata;
  logic         rvalid, waitreq;
  logic [95:0]  tparam;
  logic         start, abort;
  logic         done = 1'b0;
  logic [319:0] res = '0;
`ifdef MEM_TEST_CTRL_IRQ_EN
  logic         irq;
`endif

  mem_test_ctrl #(.TIMEOUT_CYCLES(32'd16), .CSR_ADDR_W(4)) dut (
    .clk_sys_i           (clk),
    .rst_n_i             (rst_n),
    .csr_address_i       (addr),
    .csr_read_i          (rd),
    .csr_write_i         (wr),
    .csr_writedata_i     (wdata),
    .csr_readdata_o      (rdata),
    .csr_readdatavalid_o (rvalid),
    .csr_waitrequest_o   (waitreq),
    .test_param_o        (tparam),
    .start_o             (start),
    .abort_o             (abort),
`ifdef MEM_TEST_CTRL_IRQ_EN
    .irq_o               (irq),
`endif
    .done_i              (done),
    .res_i               (res)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_cmp = 0, n_fail = 0;
  int sim_starts = 0, sim_aborts = 0;
  bit wait_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (start) sim_starts++;
    if (abort) sim_aborts++;
    if (waitreq) wait_seen = 1'b1;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout: bench still running at %0t, required finish", $time);
    $fatal(1, "timeout");
  end

  // Reference model of the register-visible state
  logic [31:0] m_csr[3];
  logic [31:0] m_sh[10];
  bit m_busy, m_done, m_to, m_werr;
  int m_starts = 0, m_aborts = 0;

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_csr[i] = '0;
    for (int i = 0; i < 10; i++) m_sh[i] = '0;
    m_busy = 0; m_done = 0; m_to = 0; m_werr = 0;
  endtask

  function automatic logic [31:0] exp_reg(input int a);
    if (a == 0) return {27'd0, m_werr, m_to, m_done, m_busy, 1'b0};
    if (a >= 1 && a <= 3) return m_csr[a-1];
    if (a >= 4 && a <= 13) return m_sh[a-4];
    return 32'd0;
  endfunction

  function automatic logic [319:0] pack_res(input logic [31:0] w[10]);
    logic [319:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[319-32*i -: 32] = w[i];
    return r;
  endfunction

  task automatic check(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic bus_write(input int a, input logic [31:0] d);
    addr = 4'(a); wdata = d; wr = 1'b1;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input int a, output logic [31:0] d);
    addr = 4'(a); rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    check("rvalid", 96'(rvalid), 96'(1));
    d = rdata;
  endtask

  task automatic read_chk(input string nm, input int a);
    logic [31:0] d;
    bus_read(a, d);
    check(nm, 96'(d), 96'(exp_reg(a)));
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic do_start(output int p);
    bus_write(0, 32'h1);
    p = cyc;
    check("start_pulse", 96'(start), 96'(1));
    m_busy = 1; m_done = 0; m_to = 0; m_starts++;
    check("test_param", tparam, {m_csr[2], m_csr[1], m_csr[0]});
  endtask

  // Runs one test from START: done_i driven d cycles after the start pulse,
  // optional dropped CSR write early in RUN
  task automatic run_to_end(input int p, input int d, input logic [31:0] w[10],
                            input bit busy_wr, input int bw_addr, input logic [31:0] bw_data);
    for (int c = p + 1; c <= p + 22; c++) begin
      wait_to(c);
      if (c == p + TO)     check("abort_early", 96'(abort), 96'(0));
      if (c == p + TO + 1) check("abort_at_limit", 96'(abort), 96'(d > TO));
      done = (c == p + d);
      if (c == p + d) res = pack_res(w);
      wr = busy_wr && (c == p + 1);
      addr = 4'(bw_addr); wdata = bw_data;
    end
    done = 1'b0; wr = 1'b0;
    if (d <= TO) begin
      for (int i = 0; i < 10; i++) m_sh[i] = w[i];
      m_done = 1;
    end else begin
      m_to = 1; m_aborts++;
    end
    if (busy_wr) m_werr = 1;
    m_busy = 0;
  endtask

  typedef struct {
    bit          is_wr;
    int          a;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  logic [31:0] w[10];
  logic [31:0] d32;
  int p;

  initial begin
    model_reset();

    for (int a = 0; a < 16; a++) vecs.push_back('{0, a, 32'h0, 32'h0});
    vecs.push_back('{1, 1, 32'h0000_1000, 32'h0});
    vecs.push_back('{1, 2, 32'h0000_00FF, 32'h0});
    vecs.push_back('{1, 3, 32'h0000_0001, 32'h0});
    vecs.push_back('{1, 4, 32'h5555_5555, 32'h0});
    vecs.push_back('{1, 14, 32'h0000_0007, 32'h0});
    vecs.push_back('{0, 1, 32'h0, 32'h0000_1000});
    vecs.push_back('{0, 2, 32'h0, 32'h0000_00FF});
    vecs.push_back('{0, 3, 32'h0, 32'h0000_0001});
    vecs.push_back('{0, 4, 32'h0, 32'h0});
    vecs.push_back('{0, 14, 32'h0, 32'h0});
    vecs.push_back('{0, 15, 32'h0, 32'h0});
    vecs.push_back('{0, 0, 32'h0, 32'h0});

    repeat (3) @(negedge clk);
    check("rst_start", 96'(start), 96'(0));
    check("rst_abort", 96'(abort), 96'(0));
    check("rst_rvalid", 96'(rvalid), 96'(0));
    check("rst_tparam", tparam, 96'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Register map vectors
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        bus_write(vecs[i].a, vecs[i].data);
        if (vecs[i].a >= 1 && vecs[i].a <= 3) m_csr[vecs[i].a-1] = vecs[i].data;
      end else begin
        bus_read(vecs[i].a, d32);
        check($sformatf("vec%0d_addr%0d", i, vecs[i].a), 96'(d32), 96'(vecs[i].exp));
      end
    end
    @(negedge clk);
    check("rvalid_one_cycle", 96'(rvalid), 96'(0));

    // Read and write in the same cycle return the old value
    addr = 4'd1; wdata = 32'h0000_1000; rd = 1'b1; wr = 1'b1;
    m_csr[0] = 32'h0000_1000;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    check("rdwr_old_value", 96'(rdata), 96'(32'h0000_1000));
    bus_write(1, 32'h0000_2000);
    addr = 4'd1; wdata = 32'h0000_1000; rd = 1'b1; wr = 1'b1;
    @(negedge clk);
    rd = 1'b0; wr = 1'b0;
    check("rdwr_pre_write", 96'(rdata), 96'(32'h0000_2000));
    read_chk("rdwr_post_write", 1);

    // Start, busy writes dropped, WR_ERR set and cleared, then done
    do_start(p);
    check("tparam_plan", tparam, {32'h1, 32'hFF, 32'h1000});
    read_chk("ctrl_busy", 0);
    bus_write(2, 32'h0000_DEAD);
    m_werr = 1;
    bus_write(0, 32'h1);
    read_chk("csr2_frozen", 2);
    read_chk("ctrl_wr_err", 0);
    bus_write(0, 32'h10);
    m_werr = 0;
    read_chk("ctrl_wr_err_clr", 0);
    for (int i = 0; i < 10; i++) w[i] = 32'h100 + 32'(i);
    w[0] = 32'h1; w[1] = 32'hABCD;
    done = 1'b1; res = pack_res(w);
    @(negedge clk);
    done = 1'b0;
    for (int i = 0; i < 10; i++) m_sh[i] = w[i];
    m_done = 1; m_busy = 0;
    read_chk("ctrl_done", 0);
    for (int a = 4; a < 14; a++) read_chk($sformatf("shadow_a%0d", a), a);
    check("tparam_hold", tparam, {32'h1, 32'hFF, 32'h1000});

    // Timeout with a late done_i that must be ignored
    do_start(p);
    for (int i = 0; i < 10; i++) w[i] = 32'hBAD0_0000 + 32'(i);
    run_to_end(p, TO + 2, w, 0, 0, 0);
    read_chk("ctrl_timeout", 0);
    read_chk("shadow_kept_res", 4);
    read_chk("shadow_kept_err", 5);

    // done_i on the expiry cycle wins over the timeout
    do_start(p);
    for (int i = 0; i < 10; i++) w[i] = 32'h2000 + 32'(i);
    run_to_end(p, TO, w, 0, 0, 0);
    read_chk("ctrl_tie_done", 0);
    read_chk("tie_shadow", 4);

    // DONE set and W1C of DONE in the same cycle: set wins
    do_start(p);
    wait_to(p + 3);
    for (int i = 0; i < 10; i++) w[i] = 32'h3000 + 32'(i);
    done = 1'b1; res = pack_res(w);
    bus_write(0, 32'h4);
    done = 1'b0;
    for (int i = 0; i < 10; i++) m_sh[i] = w[i];
    m_done = 1; m_busy = 0;
    read_chk("ctrl_set_wins", 0);

    // done_i while idle is ignored
    for (int i = 0; i < 10; i++) w[i] = 32'hFFFF_0000 + 32'(i);
    done = 1'b1; res = pack_res(w);
    @(negedge clk);
    done = 1'b0;
    repeat (2) @(negedge clk);
    read_chk("idle_done_ignored", 4);
    read_chk("idle_done_ctrl", 0);

    // Randomized runs against the model
    for (int it = 0; it < 40; it++) begin
      int  dd, bwa;
      bit  bw;
      logic [31:0] v;
      for (int k = 1; k <= 3; k++) begin
        if ($urandom_range(0, 1) == 1) begin
          v = $urandom;
          bus_write(k, v);
          m_csr[k-1] = v;
        end
      end
      if ($urandom_range(0, 2) == 0) begin
        v = $urandom & 32'h1C;
        bus_write(0, v);
        if (v[2]) m_done = 0;
        if (v[3]) m_to = 0;
        if (v[4]) m_werr = 0;
        read_chk("rnd_w1c", 0);
      end
      do_start(p);
      bw  = ($urandom_range(0, 3) == 0);
      bwa = $urandom_range(0, 3);
      v   = $urandom & 32'hFFFF_FF00;
      dd  = $urandom_range(bw ? 2 : 1, TO + 5);
      for (int i = 0; i < 10; i++) w[i] = $urandom;
      // a CTRL write during RUN only flags WR_ERR if it carries START
      if (bw && bwa == 0) v[0] = 1'b1;
      run_to_end(p, dd, w, bw, bwa, v);
      check("rnd_tparam", tparam, {m_csr[2], m_csr[1], m_csr[0]});
      read_chk($sformatf("rnd%0d_ctrl", it), 0);
      for (int a = 1; a < 14; a++) read_chk($sformatf("rnd%0d_a%0d", it, a), a);
    end

    // Reset in the middle of a run
    do_start(p);
    wait_to(p + 5);
    rst_n = 1'b0;
    #1;
    check("midrst_start", 96'(start), 96'(0));
    check("midrst_abort", 96'(abort), 96'(0));
    check("midrst_rvalid", 96'(rvalid), 96'(0));
    check("midrst_rdata", 96'(rdata), 96'(0));
    check("midrst_tparam", tparam, 96'(0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (25) @(negedge clk);
    read_chk("postrst_ctrl", 0);
    read_chk("postrst_csr1", 1);
    read_chk("postrst_res", 4);

    repeat (2) @(negedge clk);
    check("start_count", 96'(sim_starts), 96'(m_starts));
    check("abort_count", 96'(sim_aborts), 96'(m_aborts));
    check("waitrequest_low", 96'(wait_seen), 96'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
